string_scheduler: RTL and testbench

- Sequencing controller in front of the tuner's single tone datapath.
- Debounces the four string buttons (E, A, D, G) and a strum button, and arbitrates pending string requests round-robin.
- Grants one string at a time for a fixed note duration, or sequences E→A→D→G for a strum.
- Latches the fret vector at each grant, so the tuner plays a stable note while switches move.

---
 rtl/guitar_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/string_scheduler.sv | 164 ++++++++++++++++
 tb/tb_string_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/guitar_pkg.sv
// Shared encodings for the guitar tuner sequencing logic: FSM states, string indices,
// the default fret-vector width and the round-robin pick helper.
package guitar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    GAP   = 2'd2,
    STRUM = 2'd3
  } sched_state_e;

  localparam int STR_E = 0;
  localparam int STR_A = 1;
  localparam int STR_D = 2;
  localparam int STR_G = 3;

  localparam int FRET_W_DEF = 17;

  // Returns the first requested string at or after ptr, wrapping G back to E.
  function automatic logic [1:0] rrPick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rrPick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rrPick = idx;
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw button; emits a one-cycle
// pulse when the debounced level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  // The level only follows the synced input after an unbroken run of differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q != level_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          rise_q  <= sync2_q;
          cnt_q   <= '0;
        end else begin
          rise_q <= 1'b0;
          cnt_q  <= cnt_q + 1'b1;
        end
      end else begin
        rise_q <= 1'b0;
        cnt_q  <= '0;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/string_scheduler.sv
// Debounces the string and strum buttons, arbitrates string requests round-robin and
// sequences single notes or an E-A-D-G strum. Define SCHED_PREEMPT_EN to let a new request cut a single note short.
module string_scheduler
  import guitar_pkg::*;
#(
  parameter int FRET_W            = FRET_W_DEF,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int NOTE_CYCLES       = 25000000,
  parameter int GAP_CYCLES        = 2000000,
  parameter int STRUM_STEP_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FRET_W-1:0] frets,
  input  logic [3:0]        btn,
  input  logic              strum,
  output logic [3:0]        string_sel,
  output logic [FRET_W-1:0] fret_lat,
  output logic              note_on,
  output logic              note_start,
  output logic [1:0]        state_dbg
);

  localparam int MAX_A = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int MAX_C = (MAX_A > STRUM_STEP_CYCLES) ? MAX_A : STRUM_STEP_CYCLES;
  localparam int CNT_W = $clog2(MAX_C) + 1;

  logic [3:0]        btnRise;
  logic              strumRise;

  sched_state_e      state_q;
  logic [3:0]        pending_q;
  logic              strumPend_q;
  logic [1:0]        rrPtr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        step_q;
  logic [3:0]        stringSel_q;
  logic [FRET_W-1:0] fretLat_q;
  logic              noteOn_q;
  logic              noteStart_q;

  logic [3:0]        pendSet_d;
  logic              strumSet_d;
  logic [1:0]        grant_d;
  logic [3:0]        grantOh_d;
  logic              preemptHit;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .reset (reset),
      .raw_i (btn[i]),
      .rise_o(btnRise[i])
    );
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_strum (
    .clk   (clk),
    .reset (reset),
    .raw_i (strum),
    .rise_o(strumRise)
  );

  // Fresh edges are folded in directly so an idle scheduler grants on the very next cycle.
  assign pendSet_d  = pending_q | btnRise;
  assign strumSet_d = strumPend_q | strumRise;
  assign grant_d    = rrPick(pendSet_d, rrPtr_q);
  assign grantOh_d  = 4'b0001 << grant_d;

`ifdef SCHED_PREEMPT_EN
  assign preemptHit = |pendSet_d;
`else
  assign preemptHit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      strumPend_q <= 1'b0;
      rrPtr_q     <= '0;
      cnt_q       <= '0;
      step_q      <= '0;
      stringSel_q <= '0;
      fretLat_q   <= '0;
      noteOn_q    <= 1'b0;
      noteStart_q <= 1'b0;
    end else begin
      noteStart_q <= 1'b0;
      pending_q   <= pendSet_d;
      strumPend_q <= strumSet_d;
      case (state_q)
        IDLE: begin
          if (strumSet_d) begin
            strumPend_q <= 1'b0;
            fretLat_q   <= frets;
            stringSel_q <= 4'b0001;
            noteOn_q    <= 1'b1;
            noteStart_q <= 1'b1;
            step_q      <= '0;
            cnt_q       <= '0;
            state_q     <= STRUM;
          end else if (|pendSet_d) begin
            pending_q   <= pendSet_d & ~grantOh_d;
            rrPtr_q     <= grant_d + 2'd1;
            fretLat_q   <= frets;
            stringSel_q <= grantOh_d;
            noteOn_q    <= 1'b1;
            noteStart_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= PLAY;
          end
        end
        PLAY: begin
          if (preemptHit) begin
            stringSel_q <= '0;
            noteOn_q    <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else if (cnt_q == CNT_W'(NOTE_CYCLES - 1)) begin
            stringSel_q <= '0;
            noteOn_q    <= 1'b0;
            cnt_q       <= '0;
            state_q     <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STRUM: begin
          if (cnt_q == CNT_W'(STRUM_STEP_CYCLES - 1)) begin
            cnt_q <= '0;
            if (step_q == 2'd3) begin
              stringSel_q <= '0;
              noteOn_q    <= 1'b0;
              state_q     <= GAP;
            end else begin
              step_q      <= step_q + 2'd1;
              stringSel_q <= stringSel_q << 1;
              noteStart_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign string_sel = stringSel_q;
  assign fret_lat   = fretLat_q;
  assign note_on    = noteOn_q;
  assign note_start = noteStart_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_string_scheduler.sv
// Directed and random stimulus for string_scheduler, checked each cycle against a
// behavioural model of the button, arbitration and note-timing rules.
module tb_string_scheduler;

  localparam int FRET_W = 17;
  localparam int DEB    = 4;
  localparam int NOTE   = 10;
  localparam int GAPC   = 2;
  localparam int STEP   = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [FRET_W-1:0] frets;
  logic [3:0]        btn;
  logic              strum;
  logic [3:0]        string_sel;
  logic [FRET_W-1:0] fret_lat;
  logic              note_on;
  logic              note_start;
  logic [1:0]        state_dbg;

  int checks = 0;
  int failures = 0;
  int nStart = 0;
  int nSelA = 0;

  // Model state: per-input sync/debounce history, then scheduler bookkeeping.
  bit  mS1[5], mS2[5], mLvl[5], mRise[5];
  int  mRun[5];
  int  mState, mRr, mRemain, mStep;
  logic [3:0] mPend;
  bit  mStrumP;
  logic [3:0] eSel;
  logic [FRET_W-1:0] eFret;
  bit  eOn, eStart;

  string_scheduler #(
    .FRET_W(FRET_W), .DEBOUNCE_CYCLES(DEB), .NOTE_CYCLES(NOTE),
    .GAP_CYCLES(GAPC), .STRUM_STEP_CYCLES(STEP)
  ) dut (
    .clk(clk), .reset(reset), .frets(frets), .btn(btn), .strum(strum),
    .string_sel(string_sel), .fret_lat(fret_lat), .note_on(note_on),
    .note_start(note_start), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 5; i++) begin
      mS1[i] = 0; mS2[i] = 0; mLvl[i] = 0; mRise[i] = 0; mRun[i] = 0;
    end
    mState = 0; mRr = 0; mRemain = 0; mStep = 0; mPend = '0; mStrumP = 0;
    eSel = '0; eFret = '0; eOn = 0; eStart = 0;
  endtask

  // One clock edge of the rules, using values held before the edge.
  task automatic modelEdge();
    logic [3:0] rise;
    logic [3:0] req;
    logic [4:0] raw;
    bit sreq;
    int g;
    rise = {mRise[3], mRise[2], mRise[1], mRise[0]};
    req  = mPend | rise;
    sreq = mStrumP | mRise[4];
    raw  = {strum, btn};
    eStart = 0;
    mPend = req;
    mStrumP = sreq;
    case (mState)
      0: begin
        if (sreq) begin
          mStrumP = 0; eFret = frets; eSel = 4'b0001; eOn = 1; eStart = 1;
          mStep = 0; mRemain = STEP; mState = 3;
        end else if (req != 0) begin
          g = -1;
          for (int k = 0; k < 4; k++)
            if (g < 0 && req[(mRr + k) % 4]) g = (mRr + k) % 4;
          mPend[g] = 1'b0; mRr = (g + 1) % 4;
          eFret = frets; eSel = 4'(1 << g); eOn = 1; eStart = 1;
          mRemain = NOTE; mState = 1;
        end
      end
      1: begin
`ifdef SCHED_PREEMPT_EN
        if (req != 0) begin
          eSel = '0; eOn = 0; mState = 0;
        end else
`endif
        begin
          mRemain--;
          if (mRemain == 0) begin
            eSel = '0; eOn = 0; mRemain = GAPC; mState = 2;
          end
        end
      end
      2: begin
        mRemain--;
        if (mRemain == 0) mState = 0;
      end
      default: begin
        mRemain--;
        if (mRemain == 0) begin
          if (mStep == 3) begin
            eSel = '0; eOn = 0; mRemain = GAPC; mState = 2;
          end else begin
            mStep++; eSel = 4'(1 << mStep); eStart = 1; mRemain = STEP;
          end
        end
      end
    endcase
    for (int i = 0; i < 5; i++) begin
      if (mS2[i] != mLvl[i]) begin
        mRun[i]++;
        if (mRun[i] == DEB) begin
          mLvl[i] = mS2[i]; mRise[i] = mS2[i]; mRun[i] = 0;
        end else mRise[i] = 0;
      end else begin
        mRun[i] = 0; mRise[i] = 0;
      end
      mS2[i] = mS1[i];
      mS1[i] = raw[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    check("string_sel", string_sel, eSel);
    check("fret_lat", fret_lat, eFret);
    check("note_on", note_on, eOn);
    check("note_start", note_start, eStart);
    check("state_dbg", state_dbg, mState);
    nStart += note_start;
    if (string_sel == 4'b0010) nSelA++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    btn = b;
    run(hold);
    btn = '0;
  endtask

  task automatic pressUntilStart(input logic [3:0] b);
    int i;
    for (i = 0; i < 40; i++) begin
      btn = (i < 8) ? b : 4'b0000;
      tick();
      if (note_start) break;
    end
    btn = '0;
    check("wait_note_start", note_start, 1);
  endtask

  initial begin
    reset = 1'b1; btn = '0; strum = 1'b0; frets = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel", string_sel, 0);
    check("reset_fret", fret_lat, 0);
    check("reset_on", note_on, 0);
    check("reset_state", state_dbg, 0);
    @(negedge clk) reset = 1'b0;

    // Single A press: one pulse, ten A cycles, latched frets.
    frets = 17'h00005;
    nStart = 0; nSelA = 0;
    press(4'b0010, 8);
    run(20);
    check("a_starts", nStart, 1);
    check("a_cycles", nSelA, NOTE);
    check("a_fret", fret_lat, 17'h00005);

    // E and G together, then E alone with the pointer back at E.
    frets = 17'h00111;
    press(4'b1001, 8);
    run(30);
    press(4'b0001, 8);
    run(25);

    // Strum during an A note; frets move mid-strum.
    nStart = 0;
    frets = 17'h00042;
    press(4'b0010, 8);
    strum = 1'b1;
    run(8);
    strum = 1'b0;
    run(12);
    frets = 17'h1ABCD;
    run(30);
    check("strum_starts", nStart, 5);

    // Two-cycle glitch on D must not register.
    press(4'b0100, 2);
    run(12);
    check("glitch_sel", string_sel, 0);

    // Reset in the fifth PLAY cycle silences the outputs immediately.
    pressUntilStart(4'b0001);
    run(4);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_sel", string_sel, 0);
    check("rst_mid_on", note_on, 0);
    check("rst_mid_state", state_dbg, 0);
    modelReset();
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    run(20);

    // D press during an E note (cut short only when preemption is built in).
    pressUntilStart(4'b0001);
    run(2);
    press(4'b0100, 8);
    run(25);

    // Random button, strum and fret activity.
    for (int it = 0; it < 200; it++) begin
      btn   = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      strum = ($urandom_range(0, 7) == 0);
      frets = FRET_W'($urandom);
      run($urandom_range(1, 12));
    end
    btn = '0; strum = 1'b0;
    run(120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
